// File: rtl/muldiv_nbit_pkg.sv
// Shared types for the two iterative arithmetic engines.
package muldiv_nbit_pkg;

  // Per-engine handshake state: idle (ready) or iterating.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } eng_state_e;

endpackage : muldiv_nbit_pkg

// File: rtl/muldiv_div_core.sv
// Iterative radix-2 restoring divider, signed or unsigned, SIZE+1 cycles per op.
module muldiv_div_core
  import muldiv_nbit_pkg::*;
#(
  parameter int unsigned SIZE = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            div_start,
  output logic            div_ready,
  output logic            div_valid,
  output logic            div_error,
  input  logic            div_is_signed,
  input  logic [SIZE-1:0] div_dividend,
  input  logic [SIZE-1:0] div_divisor,
  output logic [SIZE-1:0] div_quotient,
  output logic [SIZE-1:0] div_remainder
);

  localparam int unsigned CW = $clog2(SIZE + 1);
  localparam int unsigned XW = SIZE + 1;

  eng_state_e      state_q;
  logic [CW-1:0]   cnt_q;
  logic [SIZE-1:0] quo_q;
  logic [SIZE-1:0] rem_q;
  logic [SIZE-1:0] dvs_q;
  logic            q_neg_q;
  logic            r_neg_q;
  logic            dvs_zero_q;
  logic            ready_q;
  logic            valid_q;
  logic            error_q;
  logic [SIZE-1:0] quotient_q;
  logic [SIZE-1:0] remainder_q;

  logic [XW-1:0]   dvd_ext_c;
  logic [XW-1:0]   dvs_ext_c;
  logic [XW-1:0]   dvd_mag_c;
  logic [XW-1:0]   dvs_mag_c;
  logic [XW-1:0]   rem_shift_c;
  logic            fits_c;
  logic [SIZE-1:0] rem_d;
  logic [SIZE-1:0] quo_fix_c;
  logic [SIZE-1:0] rem_fix_c;

  // Operand magnitudes in SIZE+1 bits so the most-negative value negates cleanly.
  always_comb begin
    dvd_ext_c = {div_is_signed & div_dividend[SIZE-1], div_dividend};
    dvs_ext_c = {div_is_signed & div_divisor[SIZE-1], div_divisor};
    dvd_mag_c = dvd_ext_c[XW-1] ? (~dvd_ext_c + XW'(1)) : dvd_ext_c;
    dvs_mag_c = dvs_ext_c[XW-1] ? (~dvs_ext_c + XW'(1)) : dvs_ext_c;
  end

  // One restoring step plus final sign correction of the magnitudes.
  always_comb begin
    rem_shift_c = {rem_q, quo_q[SIZE-1]};
    fits_c      = (rem_shift_c >= {1'b0, dvs_q});
    rem_d       = fits_c ? SIZE'(rem_shift_c - {1'b0, dvs_q}) : SIZE'(rem_shift_c);
    quo_fix_c   = q_neg_q ? (~quo_q + SIZE'(1)) : quo_q;
    rem_fix_c   = r_neg_q ? (~rem_q + SIZE'(1)) : rem_q;
  end

  // Handshake FSM, iteration datapath and registered results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dvs_zero_q  <= 1'b0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (div_start) begin
            state_q    <= ST_BUSY;
            ready_q    <= 1'b0;
            cnt_q      <= '0;
            quo_q      <= SIZE'(dvd_mag_c);
            rem_q      <= '0;
            dvs_q      <= SIZE'(dvs_mag_c);
            q_neg_q    <= div_is_signed & (div_dividend[SIZE-1] ^ div_divisor[SIZE-1]);
            r_neg_q    <= div_is_signed & div_dividend[SIZE-1];
            dvs_zero_q <= (div_divisor == '0);
          end
        end
        ST_BUSY: begin
          if (cnt_q != CW'(SIZE)) begin
            quo_q <= {quo_q[SIZE-2:0], fits_c};
            rem_q <= rem_d;
            cnt_q <= cnt_q + CW'(1);
          end else begin
            // Divide-by-zero: magnitude loop already leaves |dividend| in rem_q.
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            valid_q     <= 1'b1;
            error_q     <= dvs_zero_q;
            quotient_q  <= dvs_zero_q ? '1 : quo_fix_c;
            remainder_q <= rem_fix_c;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign div_ready     = ready_q;
  assign div_valid     = valid_q;
  assign div_error     = error_q;
  assign div_quotient  = quotient_q;
  assign div_remainder = remainder_q;

endmodule : muldiv_div_core

// File: rtl/muldiv_mul_core.sv
// Iterative radix-2 shift-add multiplier, signed or unsigned, SIZE+1 cycles per op.
module muldiv_mul_core
  import muldiv_nbit_pkg::*;
#(
  parameter int unsigned SIZE = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mul_start,
  output logic              mul_ready,
  output logic              mul_valid,
  input  logic              mul_is_signed,
  input  logic [SIZE-1:0]   mul_multiplicand,
  input  logic [SIZE-1:0]   mul_multiplier,
  output logic [2*SIZE-1:0] mul_product
);

  localparam int unsigned CW = $clog2(SIZE + 1);
  localparam int unsigned XW = SIZE + 1;
  localparam int unsigned PW = 2 * SIZE;

  eng_state_e      state_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   acc_q;
  logic [SIZE-1:0] mcand_q;
  logic            neg_q;
  logic            ready_q;
  logic            valid_q;
  logic [PW-1:0]   product_q;

  logic [XW-1:0]   mcand_ext_c;
  logic [XW-1:0]   mplier_ext_c;
  logic [XW-1:0]   mcand_mag_c;
  logic [XW-1:0]   mplier_mag_c;
  logic [XW-1:0]   sum_c;
  logic [PW-1:0]   acc_d;
  logic [PW-1:0]   prod_fix_c;

  // Operand magnitudes in SIZE+1 bits so the most-negative value negates cleanly.
  always_comb begin
    mcand_ext_c  = {mul_is_signed & mul_multiplicand[SIZE-1], mul_multiplicand};
    mplier_ext_c = {mul_is_signed & mul_multiplier[SIZE-1], mul_multiplier};
    mcand_mag_c  = mcand_ext_c[XW-1] ? (~mcand_ext_c + XW'(1)) : mcand_ext_c;
    mplier_mag_c = mplier_ext_c[XW-1] ? (~mplier_ext_c + XW'(1)) : mplier_ext_c;
  end

  // One add-and-shift-right step; low half starts as the multiplier and drains out.
  always_comb begin
    sum_c      = {1'b0, acc_q[PW-1:SIZE]} + (acc_q[0] ? {1'b0, mcand_q} : XW'(0));
    acc_d      = {sum_c, acc_q[SIZE-1:1]};
    prod_fix_c = neg_q ? (~acc_q + PW'(1)) : acc_q;
  end

  // Handshake FSM, iteration datapath and registered product.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      neg_q     <= 1'b0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      product_q <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mul_start) begin
            state_q <= ST_BUSY;
            ready_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= {SIZE'(0), SIZE'(mplier_mag_c)};
            mcand_q <= SIZE'(mcand_mag_c);
            neg_q   <= mul_is_signed & (mul_multiplicand[SIZE-1] ^ mul_multiplier[SIZE-1]);
          end
        end
        ST_BUSY: begin
          if (cnt_q != CW'(SIZE)) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CW'(1);
          end else begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b1;
            valid_q   <= 1'b1;
            product_q <= prod_fix_c;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mul_ready   = ready_q;
  assign mul_valid   = valid_q;
  assign mul_product = product_q;

endmodule : muldiv_mul_core

// File: rtl/muldiv_nbit.sv
// Two independent iterative engines (divide and multiply) for the M-extension path.
module muldiv_nbit
  import muldiv_nbit_pkg::*;
#(
  parameter int unsigned SIZE = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              div_start,
  output logic              div_ready,
  output logic              div_valid,
  output logic              div_error,
  input  logic              div_is_signed,
  input  logic [SIZE-1:0]   div_dividend,
  input  logic [SIZE-1:0]   div_divisor,
  output logic [SIZE-1:0]   div_quotient,
  output logic [SIZE-1:0]   div_remainder,
  input  logic              mul_start,
  output logic              mul_ready,
  output logic              mul_valid,
  input  logic              mul_is_signed,
  input  logic [SIZE-1:0]   mul_multiplicand,
  input  logic [SIZE-1:0]   mul_multiplier,
  output logic [2*SIZE-1:0] mul_product
);

  muldiv_div_core #(.SIZE(SIZE)) u_div (
    .clk           (clk),
    .rst_n         (rst_n),
    .div_start     (div_start),
    .div_ready     (div_ready),
    .div_valid     (div_valid),
    .div_error     (div_error),
    .div_is_signed (div_is_signed),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder)
  );

  muldiv_mul_core #(.SIZE(SIZE)) u_mul (
    .clk              (clk),
    .rst_n            (rst_n),
    .mul_start        (mul_start),
    .mul_ready        (mul_ready),
    .mul_valid        (mul_valid),
    .mul_is_signed    (mul_is_signed),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_product      (mul_product)
  );

endmodule : muldiv_nbit

// File: tb/tb_muldiv_nbit.sv
// Self-checking bench: SIZE=8 and SIZE=33 instances, scoreboard queues per engine.
module tb_muldiv_nbit;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       err;
  } div8_exp_t;

  typedef struct packed {
    logic [32:0] q;
    logic [32:0] r;
    logic        err;
  } div33_exp_t;

  logic clk;
  logic rst_n;

  logic        d8_div_start, d8_div_ready, d8_div_valid, d8_div_error, d8_div_is_signed;
  logic [7:0]  d8_div_dividend, d8_div_divisor, d8_div_quotient, d8_div_remainder;
  logic        d8_mul_start, d8_mul_ready, d8_mul_valid, d8_mul_is_signed;
  logic [7:0]  d8_mul_multiplicand, d8_mul_multiplier;
  logic [15:0] d8_mul_product;

  logic        d33_div_start, d33_div_ready, d33_div_valid, d33_div_error, d33_div_is_signed;
  logic [32:0] d33_div_dividend, d33_div_divisor, d33_div_quotient, d33_div_remainder;
  logic        d33_mul_start, d33_mul_ready, d33_mul_valid, d33_mul_is_signed;
  logic [32:0] d33_mul_multiplicand, d33_mul_multiplier;
  logic [65:0] d33_mul_product;

  div8_exp_t   sb_div8[$];
  logic [15:0] sb_mul8[$];
  div33_exp_t  sb_div33[$];
  logic [65:0] sb_mul33[$];

  int n_checks;
  int n_fail;

  muldiv_nbit #(.SIZE(8)) u_dut8 (
    .clk              (clk),
    .rst_n            (rst_n),
    .div_start        (d8_div_start),
    .div_ready        (d8_div_ready),
    .div_valid        (d8_div_valid),
    .div_error        (d8_div_error),
    .div_is_signed    (d8_div_is_signed),
    .div_dividend     (d8_div_dividend),
    .div_divisor      (d8_div_divisor),
    .div_quotient     (d8_div_quotient),
    .div_remainder    (d8_div_remainder),
    .mul_start        (d8_mul_start),
    .mul_ready        (d8_mul_ready),
    .mul_valid        (d8_mul_valid),
    .mul_is_signed    (d8_mul_is_signed),
    .mul_multiplicand (d8_mul_multiplicand),
    .mul_multiplier   (d8_mul_multiplier),
    .mul_product      (d8_mul_product)
  );

  muldiv_nbit #(.SIZE(33)) u_dut33 (
    .clk              (clk),
    .rst_n            (rst_n),
    .div_start        (d33_div_start),
    .div_ready        (d33_div_ready),
    .div_valid        (d33_div_valid),
    .div_error        (d33_div_error),
    .div_is_signed    (d33_div_is_signed),
    .div_dividend     (d33_div_dividend),
    .div_divisor      (d33_div_divisor),
    .div_quotient     (d33_div_quotient),
    .div_remainder    (d33_div_remainder),
    .mul_start        (d33_mul_start),
    .mul_ready        (d33_mul_ready),
    .mul_valid        (d33_mul_valid),
    .mul_is_signed    (d33_mul_is_signed),
    .mul_multiplicand (d33_mul_multiplicand),
    .mul_multiplier   (d33_mul_multiplier),
    .mul_product      (d33_mul_product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference models (8-bit) using 64-bit integer arithmetic.
  function automatic longint ext8(input logic s, input logic [7:0] v);
    return s ? longint'({{56{v[7]}}, v}) : longint'({56'd0, v});
  endfunction

  function automatic logic [7:0] ref_div_q(input logic s, input logic [7:0] a, input logic [7:0] b);
    if (b == 8'd0) return 8'hFF;
    return 8'(ext8(s, a) / ext8(s, b));
  endfunction

  function automatic logic [7:0] ref_div_r(input logic s, input logic [7:0] a, input logic [7:0] b);
    if (b == 8'd0) return a;
    return 8'(ext8(s, a) % ext8(s, b));
  endfunction

  function automatic logic [15:0] ref_mul(input logic s, input logic [7:0] a, input logic [7:0] b);
    return 16'(ext8(s, a) * ext8(s, b));
  endfunction

  // Scoreboard monitors: compare each valid pulse with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && d8_div_valid === 1'b1) begin
      div8_exp_t e;
      n_checks++;
      if (sb_div8.size() == 0) begin
        n_fail++;
        $display("FAIL div8_unexpected_valid: got q=%h r=%h, required no completion", d8_div_quotient, d8_div_remainder);
      end else begin
        e = sb_div8.pop_front();
        if ({d8_div_quotient, d8_div_remainder, d8_div_error} !== {e.q, e.r, e.err}) begin
          n_fail++;
          $display("FAIL div8_result: got q=%h r=%h err=%b, required q=%h r=%h err=%b",
                   d8_div_quotient, d8_div_remainder, d8_div_error, e.q, e.r, e.err);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && d8_mul_valid === 1'b1) begin
      logic [15:0] e;
      n_checks++;
      if (sb_mul8.size() == 0) begin
        n_fail++;
        $display("FAIL mul8_unexpected_valid: got p=%h, required no completion", d8_mul_product);
      end else begin
        e = sb_mul8.pop_front();
        if (d8_mul_product !== e) begin
          n_fail++;
          $display("FAIL mul8_result: got p=%h, required p=%h", d8_mul_product, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && d33_div_valid === 1'b1) begin
      div33_exp_t e;
      n_checks++;
      if (sb_div33.size() == 0) begin
        n_fail++;
        $display("FAIL div33_unexpected_valid: got q=%h r=%h, required no completion", d33_div_quotient, d33_div_remainder);
      end else begin
        e = sb_div33.pop_front();
        if ({d33_div_quotient, d33_div_remainder, d33_div_error} !== {e.q, e.r, e.err}) begin
          n_fail++;
          $display("FAIL div33_result: got q=%h r=%h err=%b, required q=%h r=%h err=%b",
                   d33_div_quotient, d33_div_remainder, d33_div_error, e.q, e.r, e.err);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && d33_mul_valid === 1'b1) begin
      logic [65:0] e;
      n_checks++;
      if (sb_mul33.size() == 0) begin
        n_fail++;
        $display("FAIL mul33_unexpected_valid: got p=%h, required no completion", d33_mul_product);
      end else begin
        e = sb_mul33.pop_front();
        if (d33_mul_product !== e) begin
          n_fail++;
          $display("FAIL mul33_result: got p=%h, required p=%h", d33_mul_product, e);
        end
      end
    end
  end

  function automatic logic valid_of(input int which);
    case (which)
      0:       return d8_div_valid;
      1:       return d8_mul_valid;
      2:       return d33_div_valid;
      default: return d33_mul_valid;
    endcase
  endfunction

  function automatic logic ready_of(input int which);
    case (which)
      0:       return d8_div_ready;
      1:       return d8_mul_ready;
      2:       return d33_div_ready;
      default: return d33_mul_ready;
    endcase
  endfunction

  // Wait at negedges (bounded) until an engine is ready to accept.
  task automatic wait_ready(input int which);
    int w;
    w = 0;
    @(negedge clk);
    while (ready_of(which) !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (ready_of(which) !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout engine %0d: got ready=0, required ready=1 within 100 cycles", which);
    end
  endtask

  // Count edges after acceptance until valid is seen (bounded).
  task automatic wait_valid(input int which, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (valid_of(which) !== 1'b1 && n < 80);
    if (valid_of(which) !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL valid_timeout engine %0d: got no valid, required valid within 80 cycles", which);
    end
  endtask

  task automatic issue_div8(input logic s, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] eq, input logic [7:0] er, input logic ee, input bit push);
    wait_ready(0);
    d8_div_is_signed = s;
    d8_div_dividend  = a;
    d8_div_divisor   = b;
    d8_div_start     = 1'b1;
    if (push) sb_div8.push_back('{q: eq, r: er, err: ee});
    @(posedge clk);
    #1;
    d8_div_start = 1'b0;
  endtask

  task automatic issue_mul8(input logic s, input logic [7:0] a, input logic [7:0] b, input logic [15:0] ep);
    wait_ready(1);
    d8_mul_is_signed    = s;
    d8_mul_multiplicand = a;
    d8_mul_multiplier   = b;
    d8_mul_start        = 1'b1;
    sb_mul8.push_back(ep);
    @(posedge clk);
    #1;
    d8_mul_start = 1'b0;
  endtask

  task automatic issue_div33(input logic s, input logic [32:0] a, input logic [32:0] b,
                             input logic [32:0] eq, input logic [32:0] er, input logic ee);
    wait_ready(2);
    d33_div_is_signed = s;
    d33_div_dividend  = a;
    d33_div_divisor   = b;
    d33_div_start     = 1'b1;
    sb_div33.push_back('{q: eq, r: er, err: ee});
    @(posedge clk);
    #1;
    d33_div_start = 1'b0;
  endtask

  task automatic issue_mul33(input logic s, input logic [32:0] a, input logic [32:0] b, input logic [65:0] ep);
    wait_ready(3);
    d33_mul_is_signed    = s;
    d33_mul_multiplicand = a;
    d33_mul_multiplier   = b;
    d33_mul_start        = 1'b1;
    sb_mul33.push_back(ep);
    @(posedge clk);
    #1;
    d33_mul_start = 1'b0;
  endtask

  // Bounded wait until every expectation has been consumed.
  task automatic drain();
    int w;
    w = 0;
    while ((sb_div8.size() + sb_mul8.size() + sb_div33.size() + sb_mul33.size()) != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if ((sb_div8.size() + sb_mul8.size() + sb_div33.size() + sb_mul33.size()) != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d outstanding results, required 0",
               sb_div8.size() + sb_mul8.size() + sb_div33.size() + sb_mul33.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({d8_div_ready, d8_div_valid, d8_div_error, d8_mul_ready, d8_mul_valid} !== 5'b10010) begin
      n_fail++;
      $display("FAIL reset_flags8: got %b, required 10010",
               {d8_div_ready, d8_div_valid, d8_div_error, d8_mul_ready, d8_mul_valid});
    end
    n_checks++;
    if ({d8_div_quotient, d8_div_remainder, d8_mul_product} !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data8: got q=%h r=%h p=%h, required all 0", d8_div_quotient, d8_div_remainder, d8_mul_product);
    end
    n_checks++;
    if ({d33_div_ready, d33_div_valid, d33_div_error, d33_mul_ready, d33_mul_valid} !== 5'b10010) begin
      n_fail++;
      $display("FAIL reset_flags33: got %b, required 10010",
               {d33_div_ready, d33_div_valid, d33_div_error, d33_mul_ready, d33_mul_valid});
    end
    n_checks++;
    if ({d33_div_quotient, d33_div_remainder, d33_mul_product} !== 132'd0) begin
      n_fail++;
      $display("FAIL reset_data33: got q=%h r=%h p=%h, required all 0", d33_div_quotient, d33_div_remainder, d33_mul_product);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // 255*255: busy for E1..E8, valid after E9, busy starts ignored.
  task automatic test_latency();
    issue_mul8(1'b0, 8'hFF, 8'hFF, 16'hFE01);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (d8_mul_ready !== 1'b0 || d8_mul_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL latency_busy E%0d: got ready=%b valid=%b, required ready=0 valid=0", k, d8_mul_ready, d8_mul_valid);
      end
      d8_mul_multiplicand = 8'h03;
      d8_mul_multiplier   = 8'h03;
      d8_mul_start        = (k < 8);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (d8_mul_ready !== 1'b1 || d8_mul_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_done E9: got ready=%b valid=%b, required ready=1 valid=1", d8_mul_ready, d8_mul_valid);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (d8_mul_ready !== 1'b1 || d8_mul_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_pulse E10: got ready=%b valid=%b, required ready=1 valid=0", d8_mul_ready, d8_mul_valid);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (d8_mul_product !== 16'hFE01) begin
      n_fail++;
      $display("FAIL mul_hold: got p=%h, required p=fe01", d8_mul_product);
    end
    drain();
  endtask

  task automatic test_signed();
    issue_mul8(1'b1, 8'hFD, 8'h07, 16'hFFEB);
    issue_div8(1'b1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b1);
    drain();
  endtask

  task automatic test_corner();
    issue_div8(1'b0, 8'hC8, 8'h00, 8'hFF, 8'hC8, 1'b1, 1'b1);
    drain();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (d8_div_error !== 1'b1 || d8_div_quotient !== 8'hFF) begin
      n_fail++;
      $display("FAIL div_error_hold: got err=%b q=%h, required err=1 q=ff", d8_div_error, d8_div_quotient);
    end
    issue_div8(1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1);
    issue_div8(1'b1, 8'hFB, 8'h00, 8'hFF, 8'hFB, 1'b1, 1'b1);
    issue_mul8(1'b1, 8'h80, 8'h80, 16'h4000);
    issue_mul8(1'b1, 8'h80, 8'h7F, 16'hC080);
    drain();
  endtask

  task automatic test_wide();
    int n;
    issue_div33(1'b0, 33'h0_FFFF_FFFF, 33'h0_0000_0010, 33'h0_0FFF_FFFF, 33'h0_0000_000F, 1'b0);
    wait_valid(2, n);
    n_checks++;
    if (n != 34) begin
      n_fail++;
      $display("FAIL div33_latency: got %0d edges, required 34", n);
    end
    issue_mul33(1'b1, 33'h1_FFFF_FFFF, 33'h0_0000_0002, 66'h3_FFFF_FFFF_FFFF_FFFE);
    issue_div33(1'b1, 33'h1_FFFF_FFF9, 33'h0_0000_0002, 33'h1_FFFF_FFFD, 33'h1_FFFF_FFFF, 1'b0);
    issue_div33(1'b1, 33'h1_0000_0000, 33'h1_FFFF_FFFF, 33'h1_0000_0000, 33'h0_0000_0000, 1'b0);
    issue_mul33(1'b0, 33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF, 66'h0_FFFF_FFFE_0000_0001);
    drain();
  endtask

  // Mul and div accepted on the same edge finish together.
  task automatic test_concurrent();
    int n, n_mul, n_div;
    wait_ready(0);
    d8_div_is_signed    = 1'b1;
    d8_div_dividend     = 8'h64;
    d8_div_divisor      = 8'hF9;
    d8_div_start        = 1'b1;
    d8_mul_is_signed    = 1'b0;
    d8_mul_multiplicand = 8'h12;
    d8_mul_multiplier   = 8'h34;
    d8_mul_start        = 1'b1;
    sb_div8.push_back('{q: 8'hF2, r: 8'h02, err: 1'b0});
    sb_mul8.push_back(16'h03A8);
    @(posedge clk);
    #1;
    d8_div_start = 1'b0;
    d8_mul_start = 1'b0;
    n = 0;
    n_mul = 0;
    n_div = 0;
    while ((n_mul == 0 || n_div == 0) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (d8_mul_valid === 1'b1 && n_mul == 0) n_mul = n;
      if (d8_div_valid === 1'b1 && n_div == 0) n_div = n;
    end
    n_checks++;
    if (n_mul != 9 || n_div != 9) begin
      n_fail++;
      $display("FAIL concurrent_latency: got mul=%0d div=%0d edges, required 9 and 9", n_mul, n_div);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int n;
    issue_div8(1'b0, 8'hFF, 8'h10, 8'h0F, 8'h0F, 1'b0, 1'b1);
    wait_valid(0, n);
    n_checks++;
    if (n != 9) begin
      n_fail++;
      $display("FAIL b2b_first_latency: got %0d edges, required 9", n);
    end
    issue_div8(1'b0, 8'h50, 8'h07, 8'h0B, 8'h03, 1'b0, 1'b1);
    n_checks++;
    if (d8_div_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: got ready=%b after start in valid cycle, required 0", d8_div_ready);
    end
    wait_valid(0, n);
    n_checks++;
    if (n != 9) begin
      n_fail++;
      $display("FAIL b2b_second_latency: got %0d edges, required 9", n);
    end
    drain();
  endtask

  task automatic test_random();
    logic       s;
    logic [7:0] a, b;
    for (int i = 0; i < 12; i++) begin
      s = 1'($urandom_range(1, 0));
      a = 8'($urandom);
      b = (i == 5) ? 8'h00 : 8'($urandom);
      issue_div8(s, a, b, ref_div_q(s, a, b), ref_div_r(s, a, b), (b == 8'h00), 1'b1);
      issue_mul8(s, a, b, ref_mul(s, a, b));
      drain();
    end
  endtask

  task automatic test_reset_midop();
    int n, seen;
    issue_div8(1'b0, 8'h9A, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({d8_div_ready, d8_div_valid, d8_div_error} !== 3'b100 || {d8_div_quotient, d8_div_remainder} !== 16'd0) begin
      n_fail++;
      $display("FAIL midop_reset: got rdy=%b vld=%b err=%b q=%h r=%h, required 1 0 0 00 00",
               d8_div_ready, d8_div_valid, d8_div_error, d8_div_quotient, d8_div_remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (d8_div_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL midop_no_valid: got %0d valid pulses, required 0", seen);
    end
    issue_div8(1'b1, 8'h9A, 8'h05, 8'hEC, 8'hFE, 1'b0, 1'b1);
    wait_valid(0, n);
    n_checks++;
    if (n != 9) begin
      n_fail++;
      $display("FAIL midop_recover_latency: got %0d edges, required 9", n);
    end
    drain();
  endtask

  initial begin
    n_checks             = 0;
    n_fail               = 0;
    rst_n                = 1'b0;
    d8_div_start         = 1'b0;
    d8_div_is_signed     = 1'b0;
    d8_div_dividend      = '0;
    d8_div_divisor       = '0;
    d8_mul_start         = 1'b0;
    d8_mul_is_signed     = 1'b0;
    d8_mul_multiplicand  = '0;
    d8_mul_multiplier    = '0;
    d33_div_start        = 1'b0;
    d33_div_is_signed    = 1'b0;
    d33_div_dividend     = '0;
    d33_div_divisor      = '0;
    d33_mul_start        = 1'b0;
    d33_mul_is_signed    = 1'b0;
    d33_mul_multiplicand = '0;
    d33_mul_multiplier   = '0;

    test_reset();
    test_latency();
    test_signed();
    test_corner();
    test_wide();
    test_concurrent();
    test_back_to_back();
    test_random();
    test_reset_midop();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_muldiv_nbit
